// File: rtl/scroll_sched_ctrl.sv
// Scroll scheduler for the message-display address pointer.
// Arbitrates manual next/prev presses against a periodic auto-scroll timer.
module scroll_sched_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int MSG_LEN    = 16,
    parameter int TICK_DIV   = 25_000_000,
    parameter int HOLD_STEPS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              auto_en,
    output logic [ADDR_W-1:0] addr,
    output logic              step,
    output logic [1:0]        mode
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        S_MANUAL = 2'b00,
        S_AUTO   = 2'b01,
        S_HOLD   = 2'b10
    } state_t;

    state_t            r_state;
    logic              r_next_q;
    logic              r_prev_q;
    logic              r_req_next;
    logic              r_req_prev;
    logic [ADDR_W-1:0] r_addr;
    logic              r_step;
    logic [TW-1:0]     r_tick_cnt;
    logic [HW-1:0]     r_hold_cnt;

    logic              w_req;
    logic              w_tick;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_addr_dec;
    logic [ADDR_W-1:0] w_addr_man;

    // Simultaneous next+prev cancel each other; only a lone request counts.
    assign w_req      = r_req_next ^ r_req_prev;
    assign w_tick     = (r_state != S_MANUAL) && (r_tick_cnt == TICK_LAST);
    assign w_addr_inc = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
    assign w_addr_dec = (r_addr == '0) ? ADDR_LAST : r_addr - 1'b1;
    assign w_addr_man = r_req_next ? w_addr_inc : w_addr_dec;

    assign addr = r_addr;
    assign step = r_step;
    assign mode = r_state;

    // Rising-edge press detect; history resets high so a held button is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_q   <= 1'b1;
            r_prev_q   <= 1'b1;
            r_req_next <= 1'b0;
            r_req_prev <= 1'b0;
        end else begin
            r_next_q   <= btn_next;
            r_prev_q   <= btn_prev;
            r_req_next <= btn_next & ~r_next_q;
            r_req_prev <= btn_prev & ~r_prev_q;
        end
    end

    // Mode FSM with address stepping, tick timer and hold window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_MANUAL;
            r_addr     <= '0;
            r_step     <= 1'b0;
            r_tick_cnt <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_step <= 1'b0;
            if (w_req) begin
                r_addr <= w_addr_man;
                r_step <= 1'b1;
            end
            if (!auto_en) begin
                r_state    <= S_MANUAL;
                r_tick_cnt <= '0;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    S_MANUAL: begin
                        r_state    <= S_AUTO;
                        r_tick_cnt <= '0;
                    end
                    S_AUTO: begin
                        if (w_req) begin
                            r_state    <= S_HOLD;
                            r_tick_cnt <= '0;
                            r_hold_cnt <= '0;
                        end else if (w_tick) begin
                            r_addr     <= w_addr_inc;
                            r_step     <= 1'b1;
                            r_tick_cnt <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (w_req) begin
                            r_tick_cnt <= '0;
                            r_hold_cnt <= '0;
                        end else if (w_tick) begin
                            r_tick_cnt <= '0;
                            if (r_hold_cnt == HOLD_LAST) begin
                                r_state    <= S_AUTO;
                                r_hold_cnt <= '0;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_MANUAL;
                        r_tick_cnt <= '0;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_sched_ctrl.sv
// Bench for scroll_sched_ctrl: directed scenarios with literal checks,
// then randomized stimulus against a behavioural model.
module tb_scroll_sched_ctrl;

    localparam int AW = 4;
    localparam int L  = 10;
    localparam int TD = 4;
    localparam int HS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_next = 1'b1;
    logic          btn_prev = 1'b0;
    logic          auto_en = 1'b0;
    logic [AW-1:0] addr;
    logic          step;
    logic [1:0]    mode;

    int n_cmp = 0;
    int n_bad = 0;
    int n_steps = 0;

    // model state: mode 0 manual, 1 auto, 2 hold
    int m_addr = 0, m_step = 0, m_mode = 0;
    int m_tick = 0, m_hold = 0;
    int m_nq = 1, m_pq = 1, m_rn = 0, m_rp = 0;
    bit m_valid = 0;

    scroll_sched_ctrl #(
        .ADDR_W(AW), .MSG_LEN(L), .TICK_DIV(TD), .HOLD_STEPS(HS)
    ) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next),
        .btn_prev(btn_prev), .auto_en(auto_en),
        .addr(addr), .step(step), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one update per rising edge from the sampled inputs.
    always @(posedge clk) begin
        int d;
        bit man, tk;
        if (reset) begin
            m_addr = 0; m_step = 0; m_mode = 0; m_tick = 0; m_hold = 0;
            m_nq = 1; m_pq = 1; m_rn = 0; m_rp = 0;
        end else begin
            d   = m_rn - m_rp;
            man = (d != 0);
            tk  = (m_mode != 0) && (m_tick == TD - 1);
            m_rn = (btn_next && !m_nq) ? 1 : 0;
            m_rp = (btn_prev && !m_pq) ? 1 : 0;
            m_nq = btn_next;
            m_pq = btn_prev;
            m_step = 0;
            if (man) begin
                m_addr = (m_addr + d + L) % L;
                m_step = 1;
            end
            if (!auto_en) begin
                m_mode = 0; m_tick = 0; m_hold = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_tick = 0;
            end else if (man) begin
                m_mode = 2; m_tick = 0; m_hold = 0;
            end else if (tk) begin
                m_tick = 0;
                if (m_mode == 1) begin
                    m_addr = (m_addr + 1) % L;
                    m_step = 1;
                end else if (m_hold == HS - 1) begin
                    m_mode = 1; m_hold = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
            end else begin
                m_tick = m_tick + 1;
            end
        end
        m_valid = 1;
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("addr", int'(addr), m_addr);
            chk("step", int'(step), m_step);
            chk("mode", int'(mode), m_mode);
            if (addr >= AW'(L)) chk("addr_range", int'(addr), L - 1);
        end
        if (step) n_steps++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input bit nxt, input int hold);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        cyc(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc(2);
    endtask

    initial begin
        int s0;
        // 1: button held through reset gives no press
        cyc(3);
        reset = 1'b0;
        s0 = n_steps;
        cyc(6);
        chk("t1_addr", int'(addr), 0);
        chk("t1_steps", n_steps - s0, 0);
        btn_next = 1'b0;
        cyc(2);

        // 2: manual wrap in both directions, held button = one step
        press(0, 1);
        chk("t2_prev_wrap", int'(addr), 9);
        s0 = n_steps;
        press(1, 20);
        chk("t2_next_wrap", int'(addr), 0);
        chk("t2_one_step", n_steps - s0, 1);
        press(0, 1);
        chk("t2_prev_again", int'(addr), 9);
        press(1, 1);
        chk("t2_back_zero", int'(addr), 0);

        // 3: auto-scroll every TD cycles
        auto_en = 1'b1;
        s0 = n_steps;
        cyc(19);
        chk("t3_mode", int'(mode), 1);
        chk("t3_addr", int'(addr), 4);
        chk("t3_steps", n_steps - s0, 4);

        // 4: press coinciding with a tick: one step, then hold window
        btn_next = 1'b1;
        s0 = n_steps;
        cyc(2);
        btn_next = 1'b0;
        chk("t4_addr", int'(addr), 5);
        chk("t4_mode", int'(mode), 2);
        chk("t4_one_step", n_steps - s0, 1);
        cyc(11);
        chk("t4_hold_addr", int'(addr), 5);
        chk("t4_resume_mode", int'(mode), 1);
        cyc(1);
        chk("t4_resume_addr", int'(addr), 6);

        // 5: simultaneous next+prev in HOLD is ignored
        press(1, 1);
        chk("t5_hold", int'(mode), 2);
        btn_next = 1'b1;
        btn_prev = 1'b1;
        cyc(3);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        chk("t5_addr", int'(addr), 7);
        chk("t5_mode", int'(mode), 2);

        // 6: reset mid-HOLD with auto_en still high
        press(1, 1);
        chk("t6_pre_mode", int'(mode), 2);
        reset = 1'b1;
        cyc(1);
        chk("t6_rst_addr", int'(addr), 0);
        chk("t6_rst_mode", int'(mode), 0);
        reset = 1'b0;
        cyc(1);
        chk("t6_auto", int'(mode), 1);
        cyc(3);
        chk("t6_no_step_yet", int'(addr), 0);
        cyc(1);
        chk("t6_first_step", int'(addr), 1);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 5) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 40) == 0) begin
                btn_next = 1'b0;
                btn_prev = 1'b0;
                cyc(1);
                btn_next = 1'b1;
                btn_prev = 1'b1;
            end
            if ($urandom_range(0, 60) == 0) auto_en = ~auto_en;
            reset = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
